multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Parametrised N-channel debouncer for keypad column/row sense lines and other mechanical inputs.
- Each channel has its own synchroniser and its own stability counter.
- A channel's clean output changes only after its input holds a new level for a programmable number of cycles.
- Adds per-channel press/release pulses plus any-key and multi-key flags. Sits between the pad pins and the keypad scanner FSM.

Parameters:
- WIDTH, 4: number of independent channels.
- STABLE_CYCLES, 50000: consecutive cycles a synchronised level must differ from sig_out before sig_out adopts it. Legal range is 2 or more; elaboration error otherwise.
- SYNC_STAGES, 2: flip-flop synchroniser depth per channel. Legal range is 2 or more.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  WIDTH  raw asynchronous inputs.
- sig_out  out  WIDTH  debounced levels.
- rise  out  WIDTH  one-cycle pulse per channel when sig_out bit goes 0->1.
- fall  out  WIDTH  one-cycle pulse per channel when sig_out bit goes 1->0.
- key_pressed  out  1  OR-reduction of sig_out.
- multi_pressed  out  1  high when two or more sig_out bits are 1.

Behaviour:
- Reset (sampled on clk):
  - All synchroniser flops, counters, sig_out, rise and fall are cleared to 0 on the same edge.
  - key_pressed and multi_pressed therefore read 0.
  - A reset mid-count discards the count; no pulse is produced.
- Synchroniser: sig_in[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Counter: cnt[i] is width max(1, clog2(STABLE_CYCLES)), unsigned. On each edge:
  - If s[i] == sig_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: sig_out[i] <= s[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 per direction.
  - Else: cnt[i] <= cnt[i] + 1.
  - rise/fall are registered and default to 0 every cycle, so they are single-cycle pulses.
- Latency: call the first edge that samples a new stable sig_in level edge 1. sig_out updates on edge SYNC_STAGES+STABLE_CYCLES. The matching rise/fall pulse is high for exactly the following cycle.
- Glitch rejection:
  - Any return of s[i] to the sig_out[i] level before the count completes clears cnt[i].
  - Pulses shorter than STABLE_CYCLES cycles (after sync) never reach sig_out.
- Channels are fully independent; simultaneous transitions on several channels produce simultaneous pulses.
- Counter never wraps, because it is cleared at STABLE_CYCLES-1.
- key_pressed and multi_pressed are combinational from registered sig_out; no extra latency.
- multi_pressed is 0 for WIDTH=1.

Optional Feature:
- Macro: MULTI_DEBOUNCER_ACTIVE_LOW_EN.
- Defined:
  - sig_in is inverted before the first synchroniser stage; the keypad pulls lines up, so pressed = 0 on the pin.
  - sig_out/rise/fall/key_pressed remain active-high "pressed" semantics.
  - Reset state is still all 0 (released). A line held low through reset is reported pressed SYNC_STAGES+STABLE_CYCLES edges after reset deasserts.
- Undefined: no inversion; sig_in high = pressed.

Decomposition:
- Package multi_debouncer_pkg:
  - function cnt_width(STABLE_CYCLES) returning max(1, clog2).
  - localparam defaults DEF_WIDTH=4, DEF_STABLE_CYCLES=50000, DEF_SYNC_STAGES=2.
- Sub-module debounce_chan:
  - One bit: synchroniser, counter, sig_out bit, rise/fall bits.
  - Instantiated WIDTH times in a generate loop.
- Top holds the optional input inversion and the key_pressed/multi_pressed reduction logic.

Test Plan (WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2 unless stated):
- Reset: sig_in=4'b1111 while reset high -> sig_out, rise, fall = 0 and key_pressed=0. After deassert, sig_out=4'b1111 on edge 6 and rise=4'b1111 for exactly one cycle.
- Clean press: sig_in 0000->0001 held -> sig_out=0001 on edge 6; rise=0001 one cycle; key_pressed=1; multi_pressed=0.
- Bounce: ch1 toggles 1,0,1,0 each cycle for 8 cycles then holds 1 -> no change during bounce. sig_out[1]=1 exactly 6 edges after the final stable 1 is first sampled. Single rise pulse only.
- Short glitch: ch2 high for 3 cycles then low -> sig_out, rise, fall stay 0 throughout.
- Multi-key and release: hold 0101 -> multi_pressed=1. Then release ch0 -> fall=0001 one cycle; multi_pressed=0; key_pressed=1.
- Mid-count reset: assert reset on edge 4 of a press -> no pulse. sig_out stays 0 until a full 6-edge window completes after reset deasserts. Repeat with MULTI_DEBOUNCER_ACTIVE_LOW_EN defined and sig_in=4'b1110 -> sig_out=4'b0001.

Source files
------------

// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg: shared defaults and counter sizing for multi_debouncer
package multi_debouncer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_STABLE_CYCLES = 50000;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one-bit synchroniser plus stability counter with press/release pulses
// Ports: clk, reset (sync, active-high), din (raw level),
//        sig_out (debounced level), rise/fall (one-cycle edge pulses)
module debounce_chan
  import multi_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sig_out,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  // The count restarts whenever s agrees with sig_out, so only an unbroken run
  // of STABLE_CYCLES differing samples flips the output; clearing at LAST keeps
  // the counter from ever wrapping.
  always_ff @(posedge clk)
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      sig_out <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == sig_out) cnt <= '0;
      else if (cnt == LAST) begin
        sig_out <= s;
        cnt <= '0;
        rise <= s;
        fall <= ~s;
      end else cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel debouncer with press/release pulses and any/multi-key flags
// Ports: clk, reset (sync, active-high), sig_in[WIDTH] (raw pins),
//        sig_out/rise/fall[WIDTH] (debounced level and edge pulses),
//        key_pressed (any sig_out set), multi_pressed (two or more set)
// Macro MULTI_DEBOUNCER_ACTIVE_LOW_EN: pins are active-low (pulled up); they are
// inverted before synchronising so every output keeps "pressed = 1" meaning.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] sig_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             key_pressed,
  output logic             multi_pressed
);
  if (STABLE_CYCLES < 2 || SYNC_STAGES < 2) begin : g_bad_params
    $error("multi_debouncer: STABLE_CYCLES and SYNC_STAGES must be at least 2");
  end
  logic [WIDTH-1:0] din;
`ifdef MULTI_DEBOUNCER_ACTIVE_LOW_EN
  assign din = ~sig_in;
`else
  assign din = sig_in;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .din(din[i]),
      .sig_out(sig_out[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  assign key_pressed = |sig_out;
  // Clearing the lowest set bit leaves something only if two or more were set;
  // for WIDTH=1 this is always 0.
  assign multi_pressed = |(sig_out & (sig_out - WIDTH'(1)));
endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: table-driven self-checking bench for multi_debouncer (WIDTH=4, STABLE_CYCLES=4, SYNC_STAGES=2)
module tb_multi_debouncer;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] sig_in, sig_out, rise, fall;
  logic key_pressed, multi_pressed;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic rst;
    logic [3:0] in;
    logic [3:0] so;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;
  vec_t q[$];
  always #5 clk = ~clk;
  multi_debouncer #(.WIDTH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .sig_in(sig_in),
    .sig_out(sig_out),
    .rise(rise),
    .fall(fall),
    .key_pressed(key_pressed),
    .multi_pressed(multi_pressed)
  );
  // Stimulus is written as logical "pressed" bits; the pin level follows the build.
  task automatic drive(input logic r, input logic [3:0] p);
    reset = r;
`ifdef MULTI_DEBOUNCER_ACTIVE_LOW_EN
    sig_in = ~p;
`else
    sig_in = p;
`endif
  endtask
  task automatic add(input logic r, input logic [3:0] in, so, ri, fa);
    q.push_back('{rst: r, in: in, so: so, ri: ri, fa: fa});
  endtask
  // n cycles holding 'in' from debounced state 'old': output flips to 'nw' on edge 6.
  task automatic seg(input logic [3:0] in, old, nw, input int n);
    for (int k = 1; k <= n; k++)
      add(1'b0, in, (k < 6) ? old : nw, (k == 6) ? (nw & ~old) : 4'b0, (k == 6) ? (old & ~nw) : 4'b0);
  endtask
  task automatic check(input string name, input logic [13:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got so=%b ri=%b fa=%b kp=%b mp=%b, expected so=%b ri=%b fa=%b kp=%b mp=%b",
               name, act[13:10], act[9:6], act[5:2], act[1], act[0],
               exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask
  initial begin
    logic [3:0] so;
    logic kp, mp;
    int edge_at;
    drive(1'b1, 4'b1111);
    add(1'b1, 4'b1111, 4'b0, 4'b0, 4'b0);
    add(1'b1, 4'b1111, 4'b0, 4'b0, 4'b0);
    seg(4'b1111, 4'b0000, 4'b1111, 7);
    seg(4'b0000, 4'b1111, 4'b0000, 7);
    seg(4'b0001, 4'b0000, 4'b0001, 7);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b0101, 4'b0001, 4'b0, 4'b0);
    seg(4'b0001, 4'b0001, 4'b0001, 8);
    seg(4'b0101, 4'b0001, 4'b0101, 7);
    seg(4'b0100, 4'b0101, 4'b0100, 7);
    for (int k = 0; k < 8; k++) add(1'b0, (k % 2 == 0) ? 4'b0110 : 4'b0100, 4'b0100, 4'b0, 4'b0);
    seg(4'b0110, 4'b0100, 4'b0110, 7);
    add(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0);
    add(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
    add(1'b1, 4'b0001, 4'b0, 4'b0, 4'b0);
    seg(4'b0001, 4'b0000, 4'b0001, 7);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i].rst, q[i].in);
      @(posedge clk);
      #1;
      so = q[i].so;
      kp = (so != 4'b0);
      mp = ($countones(so) >= 2);
      check($sformatf("row%0d", i), {sig_out, rise, fall, key_pressed, multi_pressed},
            {so, q[i].ri, q[i].fa, kp, mp});
    end
    // Simultaneous two-channel press from 0001: both rise pulses land together on edge 6.
    drive(1'b0, 4'b0111);
    edge_at = 0;
    for (int k = 1; k <= 10 && edge_at == 0; k++) begin
      @(posedge clk);
      #1;
      if (rise != 4'b0) edge_at = k;
    end
    checks++;
    if (edge_at != 6) begin
      failures++;
      $display("FAIL multi_rise_edge: got edge %0d, expected edge 6", edge_at);
    end
    check("multi_rise_value", {sig_out, rise, fall, key_pressed, multi_pressed},
          {4'b0111, 4'b0110, 4'b0000, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    check("multi_rise_end", {sig_out, rise, fall, key_pressed, multi_pressed},
          {4'b0111, 4'b0000, 4'b0000, 1'b1, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
